// File: rtl/memory_cycle_pkg.sv
// Shared encodings for the MEM stage: WB result select codes and the
// load/store handshake FSM state encoding.
package memory_cycle_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_cycle_mem_wb_reg.sv
// MEM/WB pipeline register: loads when en_i is high, holds otherwise,
// asynchronously cleared by rst_ni.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              regwrite_i,
    input  logic [1:0]        result_src_i,
    input  logic [4:0]        rd_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    output logic              regwrite_o,
    output logic [1:0]        result_src_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] pc_plus4_o
);

    logic              regwrite_q;
    logic [1:0]        result_src_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] pc_plus4_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regwrite_q   <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
        end else if (en_i) begin
            regwrite_q   <= regwrite_i;
            result_src_q <= result_src_i;
            rd_q         <= rd_i;
            alu_result_q <= alu_result_i;
            read_data_q  <= read_data_i;
            pc_plus4_q   <= pc_plus4_i;
        end
    end

    assign regwrite_o   = regwrite_q;
    assign result_src_o = result_src_q;
    assign rd_o         = rd_q;
    assign alu_result_o = alu_result_q;
    assign read_data_o  = read_data_q;
    assign pc_plus4_o   = pc_plus4_q;

endmodule

// File: rtl/memory_cycle.sv
// Pipeline MEM stage: runs loads/stores over a req/ready handshake with the
// L1 data cache, stalls upstream while a request is open, owns MEM/WB and the WB mux.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegwriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemwriteM,
    input  logic [4:0]        RdM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] pc_plus4M,
    input  logic              cache_ready,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_req,
    output logic              cache_we,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              StallM,
    output logic              RegwriteW,
    output logic [1:0]        ResultSrcW,
    output logic [4:0]        RdW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] pc_plus4W,
    output logic [DATA_W-1:0] ResultW,
    output state_t            dbg_state_o
);

    // Handshake: cache_req stays high with we/addr/wdata stable until the
    // cycle cache_ready=1; that cycle completes the request. ready is ignored
    // whenever cache_req is low.

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
    logic              memop;
    logic              req;
    logic              stall;
    logic [DATA_W-1:0] wb_rdata;

    logic              wb_regwrite;
    logic [1:0]        wb_src;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_rdat;
    logic [DATA_W-1:0] wb_pc4;

    assign memop = MemwriteM | (ResultSrcM == RES_MEM);

    always_comb begin
        state_d      = state_q;
        rdata_hold_d = rdata_hold_q;
        req          = 1'b0;
        stall        = 1'b0;
        wb_rdata     = cache_rdata;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (cache_ready) begin
                        if (!MemwriteM) rdata_hold_d = cache_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                req   = 1'b1;
                stall = 1'b1;
                if (cache_ready) begin
                    if (!MemwriteM) rdata_hold_d = cache_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // EX/MEM advances at the end of this cycle, so the op is not reissued.
                wb_rdata = rdata_hold_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
        .clk_i        (clk),
        .rst_ni       (rst),
        .en_i         (!stall),
        .regwrite_i   (RegwriteM),
        .result_src_i (ResultSrcM),
        .rd_i         (RdM),
        .alu_result_i (ALUResultM),
        .read_data_i  (wb_rdata),
        .pc_plus4_i   (pc_plus4M),
        .regwrite_o   (wb_regwrite),
        .result_src_o (wb_src),
        .rd_o         (wb_rd),
        .alu_result_o (wb_alu),
        .read_data_o  (wb_rdat),
        .pc_plus4_o   (wb_pc4)
    );

    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign cache_addr = ALUResultM[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign cache_addr = {{(ADDR_W-DATA_W){1'b0}}, ALUResultM};
        end
    endgenerate

    assign cache_we    = MemwriteM;
    assign cache_wdata = WriteDataM;
    assign cache_req   = rst & req;
    assign StallM      = rst & stall;
    assign dbg_state_o = state_q;

    // W outputs are forced low combinationally for as long as reset is held.
    assign RegwriteW  = rst & wb_regwrite;
    assign ResultSrcW = rst ? wb_src : 2'b00;
    assign RdW        = rst ? wb_rd  : 5'd0;
    assign ALUResultW = rst ? wb_alu  : '0;
    assign ReadDataW  = rst ? wb_rdat : '0;
    assign pc_plus4W  = rst ? wb_pc4  : '0;

    always_comb begin
        case (ResultSrcW)
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = pc_plus4W;
            default: ResultW = ALUResultW;
        endcase
    end

endmodule
